// File: rtl/path_frame_renderer_if.sv
// Memory-side bus of the path frame renderer: source code-map read port plus 1-bit framebuffer port.
// Latency: both memories are expected to return read data one cycle after the address is presented.
// Backpressure: none; the memories must accept one access per cycle.
interface path_frame_renderer_if #(
  parameter int CODE_W = 4,
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] src_addr_out;
  logic [CODE_W-1:0] src_data_in;
  logic              fb_we_out;
  logic [ADDR_W-1:0] fb_addr_out;
  logic              fb_data_out;
  logic              fb_data_in;

  modport master (
    output src_addr_out,
    input  src_data_in,
    output fb_we_out,
    output fb_addr_out,
    output fb_data_out,
    input  fb_data_in
  );

  modport slave (
    input  src_addr_out,
    output src_data_in,
    input  fb_we_out,
    input  fb_addr_out,
    input  fb_data_out,
    output fb_data_in
  );
endinterface

// File: rtl/path_frame_renderer.sv
// Copies a masked code map into a 1-bit framebuffer, then scans it out as VGA pixels with a movable car box.
// Latency: pixel_out and the delayed sync/blank outputs trail the raw timing inputs by exactly 2 cycles.
// Backpressure: none; copy runs one address per cycle, scan follows the VGA counters unconditionally.
module path_frame_renderer #(
  parameter int          H_RES       = 320,
  parameter int          V_RES       = 240,
  parameter int          SCALE_SHIFT = 1,
  parameter int          CODE_W      = 4,
  parameter int          ADDR_W      = 17,
  parameter int          CAR_W       = 8,
  parameter int          CAR_H       = 8,
  parameter int          CAR_SPEED   = 4,
  parameter int          CAR_X0      = 160,
  parameter int          CAR_Y0      = 130,
  parameter logic [11:0] COLOR_CAR   = 12'hF0F,
  parameter logic [11:0] COLOR_PATH  = 12'hFFF
) (
  input  logic              vclock_in,
  input  logic              reset_in,
  input  logic              reload_in,
  input  logic [CODE_W-1:0] code_mask_in,
  input  logic              move_in,
  input  logic [1:0]        dir_in,
  input  logic [9:0]        hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  path_frame_renderer_if.master mem,
  output logic              ready_out,
  output logic              phsync_out,
  output logic              pvsync_out,
  output logic              pblank_out,
  output logic [11:0]       pixel_out
);

  localparam logic [ADDR_W:0] N_LAST = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [31:0]     H_LIM  = 32'(H_RES) << SCALE_SHIFT;
  localparam logic [31:0]     V_LIM  = 32'(V_RES) << SCALE_SHIFT;
  localparam logic [9:0]      X_MAX  = 10'(H_RES - CAR_W);
  localparam logic [9:0]      Y_MAX  = 10'(V_RES - CAR_H);
  localparam logic [9:0]      STEP   = 10'(CAR_SPEED);
  localparam logic [9:0]      CW     = 10'(CAR_W);
  localparam logic [9:0]      CH     = 10'(CAR_H);

  typedef enum logic {COPY, SCAN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q;
  logic [CODE_W-1:0] mask_q;

  logic [ADDR_W-1:0] scan_addr_d, scan_addr_q;
  logic [9:0]        hc1_q, vc1_q, hc2_q, vc2_q;
  logic              hs1_q, vs1_q, bl1_q, hs2_q, vs2_q, bl2_q;

  logic [9:0]        car_x, car_y;
  logic              vs_prev_q;
  logic [10:0]       x_sum, y_sum;
  logic [9:0]        x_inc, x_dec, y_inc, y_dec;

  logic [9:0]        mx, my;
  logic              in_car, out_rng;

  // State register; reset always restarts the copy.
  always_ff @(posedge vclock_in) begin
    if (reset_in) state_q <= COPY;
    else          state_q <= state_d;
  end

  // Next state: copy ends after the write of the last address, reload only honoured while scanning.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COPY:    if (cnt_q == N_LAST) state_d = SCAN;
      SCAN:    if (reload_in)       state_d = COPY;
      default: state_d = COPY;
    endcase
  end

  // Copy address counter and mask capture on every entry into COPY.
  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      cnt_q  <= '0;
      mask_q <= code_mask_in;
    end else if (state_q == COPY) begin
      if (cnt_q != N_LAST) cnt_q <= cnt_q + 1'b1;
    end else if (reload_in) begin
      cnt_q  <= '0;
      mask_q <= code_mask_in;
    end
  end

  // Writes trail the source read address by one cycle to absorb the source read latency.
  assign mem.src_addr_out = cnt_q[ADDR_W-1:0];
  assign mem.fb_we_out    = (state_q == COPY) && (cnt_q != '0);
  assign mem.fb_addr_out  = (state_q == COPY) ? (cnt_q[ADDR_W-1:0] - ADDR_W'(1)) : scan_addr_q;
  assign mem.fb_data_out  = |(mem.src_data_in & mask_q);
  assign ready_out        = (state_q == SCAN);

  assign scan_addr_d = ADDR_W'(hcount_in >> SCALE_SHIFT)
                     + ADDR_W'(32'(vcount_in >> SCALE_SHIFT) * 32'(H_RES));

  // Two-stage timing pipeline matching the framebuffer address register plus its read latency.
  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      scan_addr_q <= '0;
      hc1_q <= '0; vc1_q <= '0; hc2_q <= '0; vc2_q <= '0;
      hs1_q <= 1'b1; vs1_q <= 1'b1; bl1_q <= 1'b1;
      hs2_q <= 1'b1; vs2_q <= 1'b1; bl2_q <= 1'b1;
    end else begin
      scan_addr_q <= scan_addr_d;
      hc1_q <= hcount_in; vc1_q <= vcount_in;
      hc2_q <= hc1_q;     vc2_q <= vc1_q;
      hs1_q <= hsync_in;  vs1_q <= vsync_in;  bl1_q <= blank_in;
      hs2_q <= hs1_q;     vs2_q <= vs1_q;     bl2_q <= bl1_q;
    end
  end

  assign phsync_out = hs2_q;
  assign pvsync_out = vs2_q;
  assign pblank_out = bl2_q;

  // Saturating car steps; the sum carries an extra bit so the clamp sees overflow past the edge.
  assign x_sum = {1'b0, car_x} + {1'b0, STEP};
  assign y_sum = {1'b0, car_y} + {1'b0, STEP};
  assign x_inc = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
  assign y_inc = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[9:0];
  assign x_dec = (car_x < STEP) ? 10'd0 : (car_x - STEP);
  assign y_dec = (car_y < STEP) ? 10'd0 : (car_y - STEP);

  // Car moves once per falling vsync edge when enabled, independent of copy/scan state.
  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      car_x     <= 10'(CAR_X0);
      car_y     <= 10'(CAR_Y0);
      vs_prev_q <= vsync_in;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_prev_q && !vsync_in && move_in) begin
        case (dir_in)
          2'd0:    car_x <= x_inc;
          2'd1:    car_x <= x_dec;
          2'd2:    car_y <= y_inc;
          default: car_y <= y_dec;
        endcase
      end
    end
  end

  assign mx      = hc2_q >> SCALE_SHIFT;
  assign my      = vc2_q >> SCALE_SHIFT;
  assign in_car  = (mx >= car_x) && (mx < car_x + CW) && (my >= car_y) && (my < car_y + CH);
  assign out_rng = (32'(hc2_q) >= H_LIM) || (32'(vc2_q) >= V_LIM);

  // Pixel colour: blanking, copy and off-map force black; the car is drawn over the path.
  always_comb begin
    pixel_out = 12'h000;
    if (bl2_q || (state_q == COPY) || out_rng) pixel_out = 12'h000;
    else if (in_car)                           pixel_out = COLOR_CAR;
    else if (mem.fb_data_in)                   pixel_out = COLOR_PATH;
  end

endmodule

// File: tb/tb_path_frame_renderer.sv
// Directed bench for path_frame_renderer with a reduced map height so several full copies fit.
// Latency: memories modelled with one-cycle registered reads; pixel checks account for 2-cycle pipe.
// Backpressure: none.
module tb_path_frame_renderer;
  localparam int H_RES  = 320;
  localparam int V_RES  = 16;
  localparam int N      = H_RES * V_RES;
  localparam int CODE_W = 4;
  localparam int ADDR_W = 17;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_in, reload_in, move_in;
  logic [CODE_W-1:0] code_mask_in;
  logic [1:0]        dir_in;
  logic [9:0]        hcount_in, vcount_in;
  logic              hsync_in, vsync_in, blank_in;
  logic              ready_out, phsync_out, pvsync_out, pblank_out;
  logic [11:0]       pixel_out;

  path_frame_renderer_if #(.CODE_W(CODE_W), .ADDR_W(ADDR_W)) mem_bus();

  path_frame_renderer #(.H_RES(H_RES), .V_RES(V_RES), .CAR_Y0(4)) dut (
    .vclock_in(clk), .reset_in(reset_in), .reload_in(reload_in),
    .code_mask_in(code_mask_in), .move_in(move_in), .dir_in(dir_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .mem(mem_bus),
    .ready_out(ready_out), .phsync_out(phsync_out), .pvsync_out(pvsync_out),
    .pblank_out(pblank_out), .pixel_out(pixel_out)
  );

  logic [CODE_W-1:0] src_mem [0:MEM_SZ-1];
  logic              fb_mem  [0:MEM_SZ-1];

  // Source map and framebuffer models, both with registered reads.
  always @(posedge clk) begin
    mem_bus.src_data_in <= src_mem[mem_bus.src_addr_out];
    if (mem_bus.fb_we_out) fb_mem[mem_bus.fb_addr_out] <= mem_bus.fb_data_out;
    mem_bus.fb_data_in <= fb_mem[mem_bus.fb_addr_out];
  end

  int checks = 0;
  int errors = 0;

  logic [11:0] pe1, pe2;
  bit          pv1, pv2;
  logic [9:0]  ph1, ph2, pq1, pq2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pstart();
    pv1 = 1'b0; pv2 = 1'b0;
  endtask

  // Drive one timing vector and check the pixel belonging to the vector from two steps earlier.
  task automatic pstep(input logic [9:0] h, input logic [9:0] v, input logic b,
                       input logic [11:0] e, input bit en);
    hcount_in = h; vcount_in = v; blank_in = b;
    if (pv2) check($sformatf("pixel h=%0d v=%0d", ph2, pq2), pixel_out, pe2);
    pe2 = pe1; pv2 = pv1; ph2 = ph1; pq2 = pq1;
    pe1 = e;   pv1 = en;  ph1 = h;   pq1 = v;
    tick();
  endtask

  task automatic pflush();
    pstep(10'd0, 10'd0, 1'b0, 12'h000, 1'b0);
    pstep(10'd0, 10'd0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic vfall();
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0; tick();
  endtask

  task automatic wait_ready(inout int cyc);
    while (!ready_out && cyc < N + 50) begin
      tick();
      cyc++;
    end
  endtask

  function automatic int fb_ones();
    int n = 0;
    for (int i = 0; i < N; i++) if (fb_mem[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int cyc;
    for (int i = 0; i < MEM_SZ; i++) begin
      src_mem[i] = '0;
      fb_mem[i]  = 1'b0;
    end
    for (int i = 0; i < N; i++) src_mem[i] = (i == 5) ? 4'b0010 : (i == 321) ? 4'b0100 : 4'b0001;

    reset_in = 1'b1; reload_in = 1'b0; move_in = 1'b0; dir_in = 2'd0;
    code_mask_in = 4'b0010; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
    pstart();
    repeat (3) tick();

    // Reset state
    check("rst ready", ready_out, 0);
    check("rst fb_we", mem_bus.fb_we_out, 0);
    check("rst src_addr", mem_bus.src_addr_out, 0);
    check("rst pixel", pixel_out, 0);
    check("rst syncs", {phsync_out, pvsync_out, pblank_out}, 3'b111);
    check("rst car_x", dut.car_x, 160);
    check("rst car_y", dut.car_y, 4);

    // Initial copy, mask changed mid-copy must be ignored
    hsync_in = 1'b1; vsync_in = 1'b1;
    reset_in = 1'b0;
    check("copy c0 src_addr", mem_bus.src_addr_out, 0);
    check("copy c0 fb_we", mem_bus.fb_we_out, 0);
    tick();
    code_mask_in = 4'b1111;
    check("copy c1 src_addr", mem_bus.src_addr_out, 1);
    check("copy c1 fb_we", mem_bus.fb_we_out, 1);
    check("copy c1 fb_addr", mem_bus.fb_addr_out, 0);
    check("copy c1 fb_data", mem_bus.fb_data_out, 0);
    repeat (5) tick();
    check("copy c6 fb_addr", mem_bus.fb_addr_out, 5);
    check("copy c6 fb_data", mem_bus.fb_data_out, 1);
    cyc = 6;
    wait_ready(cyc);
    check("copy length", cyc, N + 1);
    check("scan fb_we", mem_bus.fb_we_out, 0);
    check("fb[5]", fb_mem[5], 1);
    check("fb[321]", fb_mem[321], 0);
    check("fb ones", fb_ones(), 1);

    // Reload with new mask; a second reload pulse mid-copy is ignored
    code_mask_in = 4'b0100;
    reload_in = 1'b1; tick(); reload_in = 1'b0;
    check("reload ready", ready_out, 0);
    check("reload src_addr", mem_bus.src_addr_out, 0);
    cyc = 0;
    repeat (50) begin tick(); cyc++; end
    reload_in = 1'b1; tick(); cyc++; reload_in = 1'b0;
    wait_ready(cyc);
    check("reload length", cyc, N + 1);
    check("reload fb[321]", fb_mem[321], 1);
    check("reload fb[5]", fb_mem[5], 0);
    check("reload fb ones", fb_ones(), 1);
    check("reload car_x", dut.car_x, 160);
    check("reload car_y", dut.car_y, 4);

    // Scan of single path pixel at map (1,1)
    pstart();
    pstep(10'd2, 10'd2, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd3, 10'd2, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd1, 10'd2, 1'b0, 12'h000, 1'b1);
    pstep(10'd2, 10'd3, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd3, 10'd3, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd4, 10'd3, 1'b0, 12'h000, 1'b1);
    pstep(10'd2, 10'd1, 1'b0, 12'h000, 1'b1);
    pstep(10'd2, 10'd4, 1'b0, 12'h000, 1'b1);
    pstep(10'd3, 10'd3, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd0, 10'd0, 1'b0, 12'h000, 1'b1);
    pflush();

    // Car movement and saturation
    move_in = 1'b1; dir_in = 2'd0;
    vfall();
    check("car +x 1", dut.car_x, 164);
    repeat (39) vfall();
    check("car +x sat", dut.car_x, 312);
    check("car y hold", dut.car_y, 4);
    move_in = 1'b0;
    vfall();
    check("car no move", dut.car_x, 312);
    move_in = 1'b1; dir_in = 2'd1;
    repeat (80) vfall();
    check("car -x sat", dut.car_x, 0);
    dir_in = 2'd2;
    vfall();
    check("car +y", dut.car_y, 8);
    vfall();
    check("car +y sat", dut.car_y, 8);
    dir_in = 2'd3;
    repeat (3) vfall();
    check("car -y sat", dut.car_y, 0);
    move_in = 1'b0;

    // Car at map (0,0) overrides the path pixel
    pstart();
    pstep(10'd2,  10'd2,  1'b0, 12'hF0F, 1'b1);
    pstep(10'd16, 10'd2,  1'b0, 12'h000, 1'b1);
    pstep(10'd15, 10'd15, 1'b0, 12'hF0F, 1'b1);
    pstep(10'd15, 10'd16, 1'b0, 12'h000, 1'b1);
    pstep(10'd2,  10'd2,  1'b0, 12'hF0F, 1'b1);
    pflush();

    // Reload with all-path mask; pixels black during copy
    code_mask_in = 4'b0001;
    reload_in = 1'b1; tick(); reload_in = 1'b0;
    pstart();
    pstep(10'd2, 10'd2, 1'b0, 12'h000, 1'b1);
    pstep(10'd100, 10'd20, 1'b0, 12'h000, 1'b1);
    pflush();
    cyc = 0;
    wait_ready(cyc);
    check("reload2 ready", ready_out, 1);
    check("reload2 car_x", dut.car_x, 0);
    check("reload2 car_y", dut.car_y, 0);

    pstart();
    pstep(10'd100, 10'd20, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd640, 10'd2,  1'b0, 12'h000, 1'b1);
    pstep(10'd639, 10'd31, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd639, 10'd32, 1'b0, 12'h000, 1'b1);
    pstep(10'd2,   10'd2,  1'b0, 12'hF0F, 1'b1);
    pstep(10'd16,  10'd16, 1'b0, 12'hFFF, 1'b1);
    pstep(10'd100, 10'd20, 1'b1, 12'h000, 1'b1);
    pstep(10'd100, 10'd20, 1'b0, 12'hFFF, 1'b1);
    pflush();

    // Blank and hsync delayed by exactly two cycles
    hcount_in = 10'd100; vcount_in = 10'd20;
    blank_in = 1'b1; hsync_in = 1'b0;
    tick();
    check("pblank +1", pblank_out, 0);
    check("phsync +1", phsync_out, 1);
    tick();
    check("pblank +2", pblank_out, 1);
    check("phsync +2", phsync_out, 0);
    check("blank pixel", pixel_out, 0);
    blank_in = 1'b0; hsync_in = 1'b1;
    repeat (2) tick();

    // Reset in the middle of a copy restarts it and relatches the mask
    reload_in = 1'b1; tick(); reload_in = 1'b0;
    cyc = 0;
    while (mem_bus.src_addr_out != 1000 && cyc < N) begin tick(); cyc++; end
    check("reach addr 1000", mem_bus.src_addr_out, 1000);
    code_mask_in = 4'b0010;
    reset_in = 1'b1; tick();
    check("midrst src_addr", mem_bus.src_addr_out, 0);
    check("midrst fb_we", mem_bus.fb_we_out, 0);
    check("midrst ready", ready_out, 0);
    check("midrst car_x", dut.car_x, 160);
    reset_in = 1'b0;
    cyc = 0;
    wait_ready(cyc);
    check("midrst length", cyc, N + 1);
    check("midrst fb[5]", fb_mem[5], 1);
    check("midrst fb ones", fb_ones(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
